rx_tmr_sched: RTL
=================

// Module: rx_tmr_sched
// PURPOSE
//  Receiver-side redundancy scheduler ahead of data_dec. Collects one 14-bit
//  Hamming frame per redundant link (up to 3), selects simplex/duplex/TMR per
//  the decoded mode and err_rate, votes, and issues one avl pulse plus the
//  voted frame to data_dec. Closes the loop: data_dec mode/err_rate feed back.
// PARAMETERS
//  data_l   14  frame width (Hamming codeword), equals data_dec data_l
//  TIMEOUT  64  max COLLECT cycles before partial frame is dropped (>=2)
//  ERR_TH   4   err_rate >= ERR_TH forces TMR regardless of mode
//  CNT_W    8   width of vote_miss_cnt (VOTE_STATS_EN only)
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  ch_valid      in   3         frame valid per channel [i]
//  ch_data       in   3*data_l  channel i at [i*data_l +: data_l]
//  ch_ready      out  3         accept per channel; beat = valid & ready
//  mode          in   2         data_dec mode: 0 simplex, 1 duplex, 2/3 TMR
//  err_rate      in   4         data_dec consecutive-error count
//  avl           out  1         one-cycle frame strobe to data_dec
//  data          out  data_l    voted frame to data_dec; held between strobes
//  active_mode   out  2         mode latched for current frame (0/1/2)
//  mismatch      out  1         one-cycle pulse: copies disagreed
//  timeout_err   out  1         one-cycle pulse: partial frame dropped
//  vote_miss_cnt out  CNT_W     saturating mismatch count (VOTE_STATS_EN)
// BEHAVIOUR
//  Reset (async, immediate): avl=0, data=0, ch_ready=0, active_mode=2,
//   mismatch=0, timeout_err=0, vote_miss_cnt=0, state IDLE, got=0, tmo=0.
//   Partial frames are lost; no avl follows reset.
//  FSM IDLE -> COLLECT -> VOTE -> ISSUE -> IDLE; min 4 cycles/frame.
//  IDLE (1 cycle): eff = (err_rate>=ERR_TH) ? 2 : (mode==3 ? 2 : mode);
//   active_mode<=eff; req<= 3'b001 / 3'b011 / 3'b111; got<=0; tmo<=0.
//   mode/err_rate changes later in the frame are ignored until next IDLE.
//  COLLECT: ch_ready[i] = req[i] ? ~got[i] : 1 (non-required channels drained,
//   data discarded). Beat on i: capture ch_data slice, got[i]<=1.
//   Exit to VOTE the cycle after (got|beats)==req. tmo increments each cycle;
//   if tmo==TIMEOUT-1 and not complete: timeout_err pulse, -> IDLE, no avl.
//   Completion and timeout on same cycle: completion wins, no timeout_err.
//  ch_ready=0 for all channels in IDLE, VOTE, ISSUE.
//  VOTE: simplex: r=d0. duplex: d0==d1 ? r=d0 : mismatch pulse, -> IDLE,
//   no avl. TMR: r=(d0&d1)|(d1&d2)|(d0&d2) bitwise; mismatch pulse if any
//   copy != r, frame still issued. data<=r registered at end of VOTE.
//  ISSUE: avl=1 exactly this cycle, data valid with it; -> IDLE.
//  Latency: last accepting beat at edge N -> avl high in cycle N+2.
//  No backpressure from data_dec; avl never high two consecutive cycles.
// CONFIGURATION
//  VOTE_STATS_EN defined: vote_miss_cnt present; +1 per mismatch pulse,
//   saturates at 2^CNT_W-1, cleared only by rst.
//  Undefined: port vote_miss_cnt and its logic absent; all else identical.
// TESTING
//  1 mode=0, ch0 beat 14'h01A5 -> avl 2 cycles later, data=14'h01A5;
//    ch_ready[2:1]=2'b11 throughout COLLECT, active_mode=0.
//  2 mode=2, d0=d1=14'h0F0F, d2=14'h3000 -> data=14'h0F0F, avl=1,
//    mismatch=1 same cycle as VOTE, exactly one pulse.
//  3 mode=1, d0=14'h0001, d1=14'h0002 -> mismatch pulse, no avl; next frame
//    d0=d1=14'h0002 -> avl, data=14'h0002.
//  4 mode=2, only ch0/ch1 valid -> timeout_err pulse in 64th COLLECT cycle,
//    no avl, returns IDLE; beat completing on cycle 64 -> avl, no timeout_err.
//  5 mode=0, err_rate=4 -> active_mode=2, waits for all 3 channels; err_rate
//    drops to 0 mid-COLLECT -> current frame stays TMR.
//  6 rst mid-COLLECT -> all outputs reset values at once, next frame normal;
//    VOTE_STATS_EN, 300 TMR mismatches -> vote_miss_cnt=255.

Source files
------------

// File: rtl/rx_tmr_sched.sv
// rx_tmr_sched: receiver-side redundancy scheduler placed ahead of data_dec.
// The block collects one frame from each required link and picks simplex,
// duplex or TMR from the decoded mode and err_rate. It then votes and sends
// one avl strobe with the voted frame.
// Optional feature: define VOTE_STATS_EN to add the saturating vote_miss_cnt
// output and its counter.
module rx_tmr_sched #(
    parameter int data_l  = 14,
    parameter int TIMEOUT = 64,
    parameter int ERR_TH  = 4
`ifdef VOTE_STATS_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            ch_valid,
    input  logic [3*data_l-1:0]   ch_data,
    output logic [2:0]            ch_ready,
    input  logic [1:0]            mode,
    input  logic [3:0]            err_rate,
    output logic                  avl,
    output logic [data_l-1:0]     data,
    output logic [1:0]            active_mode,
    output logic                  mismatch,
    output logic                  timeout_err
`ifdef VOTE_STATS_EN
    , output logic [CNT_W-1:0]    vote_miss_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VOTE, S_ISSUE} state_t;

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              state_q, state_d;
    logic [2:0]          req_q, got_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [1:0]          am_q;
    logic [data_l-1:0]   cap_q [3];
    logic [data_l-1:0]   data_q;

    logic [2:0]          beats;
    logic                done;
    logic                tmo_last;
    logic [1:0]          eff;
    logic [data_l-1:0]   maj;
    logic [data_l-1:0]   vote_r;
    logic                vote_bad;

    assign beats    = ch_valid & ch_ready;
    assign done     = ((got_q | beats) == req_q);
    assign tmo_last = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Effective redundancy: a high error rate or mode 3 forces TMR.
    always_comb begin
        // NOTE: a default assignment on every path keeps this logic purely combinational, so no latch is inferred.
        eff = mode;
        if (err_rate >= 4'(ERR_TH) || mode == 2'd3) eff = 2'd2;
    end

    // Bitwise majority of the captured copies and the disagreement flag.
    always_comb begin
        maj      = (cap_q[0] & cap_q[1]) | (cap_q[1] & cap_q[2]) | (cap_q[0] & cap_q[2]);
        vote_r   = cap_q[0];
        vote_bad = 1'b0;
        case (am_q)
            2'd0: vote_bad = 1'b0;
            2'd1: vote_bad = (cap_q[0] != cap_q[1]);
            default: begin
                vote_r   = maj;
                vote_bad = (cap_q[0] != maj) | (cap_q[1] != maj) | (cap_q[2] != maj);
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        // NOTE: clocked state uses non-blocking assignments, so every flop samples values from before the edge.
        else     state_q <= state_d;
    end

    // Next-state logic: a duplex disagreement drops the frame, and completion takes priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_COLLECT;
            S_COLLECT: begin
                if (done)          state_d = S_VOTE;
                else if (tmo_last) state_d = S_IDLE;
            end
            S_VOTE:    state_d = (am_q == 2'd1 && vote_bad) ? S_IDLE : S_ISSUE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state: handshakes and one-cycle pulses.
    always_comb begin
        ch_ready    = 3'b000;
        avl         = 1'b0;
        mismatch    = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            S_COLLECT: begin
                ch_ready    = ~req_q | ~got_q;
                timeout_err = tmo_last & ~done;
            end
            S_VOTE:  mismatch = vote_bad;
            S_ISSUE: avl      = 1'b1;
            default: ;
        endcase
    end

    // Per-frame bookkeeping, channel capture and the held output frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= 3'b000;
            got_q  <= 3'b000;
            tmo_q  <= '0;
            am_q   <= 2'd2;
            data_q <= '0;
            // NOTE: the capture registers are cleared as well, so the voter never reads X after reset.
            for (int i = 0; i < 3; i++) cap_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    am_q  <= eff;
                    req_q <= (eff == 2'd0) ? 3'b001 : (eff == 2'd1) ? 3'b011 : 3'b111;
                    got_q <= 3'b000;
                    tmo_q <= '0;
                end
                S_COLLECT: begin
                    got_q <= got_q | (beats & req_q);
                    tmo_q <= tmo_q + 1'b1;
                    for (int i = 0; i < 3; i++)
                        if (beats[i] && req_q[i]) cap_q[i] <= ch_data[i*data_l +: data_l];
                end
                S_VOTE: if (state_d == S_ISSUE) data_q <= vote_r;
                default: ;
            endcase
        end
    end

    assign data        = data_q;
    assign active_mode = am_q;

`ifdef VOTE_STATS_EN
    logic [CNT_W-1:0] miss_q;

    // Saturating count of mismatch pulses, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        miss_q <= '0;
        else if (mismatch && ~&miss_q)  miss_q <= miss_q + 1'b1;
    end

    assign vote_miss_cnt = miss_q;
`endif

endmodule
